uart_tx_arbiter: RTL

Round-robin arbiter and sequencer that shares one UART transmitter (`tm_top`) between `NREQ` byte producers, such as the host echo path and the image-filter output. It accepts one byte at a time over a valid/ready handshake and launches it with a one-cycle `o_tx_enable` pulse. It then waits for the transmitter's `i_tx_done`, enforces a minimum inter-byte gap, and recovers from a transmitter that never reports done. It sits between the producers and `tm_top` in the TX chain.

---
 rtl/uart_tx_arbiter_if.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Producer handshake and transmitter-side bundle for uart_tx_arbiter.
// Revision : 1.0
// =============================================================================
interface uart_tx_arbiter_if #(
    parameter int D_BITS = 8,
    parameter int NREQ   = 2
);
    logic [NREQ-1:0]        i_req_valid;
    logic [NREQ*D_BITS-1:0] i_req_data;
    logic [NREQ-1:0]        o_req_ready;
    logic [D_BITS-1:0]      o_tx_data;
    logic                   o_tx_enable;
    logic                   i_tx_done;
    logic [NREQ-1:0]        o_grant;
    logic                   o_busy;
    logic                   o_timeout;

    // slave is the arbiter itself; master is the producers plus tm_top.
    modport slave (
        input  i_req_valid, i_req_data, i_tx_done,
        output o_req_ready, o_tx_data, o_tx_enable, o_grant, o_busy, o_timeout
    );

    modport master (
        output i_req_valid, i_req_data, i_tx_done,
        input  o_req_ready, o_tx_data, o_tx_enable, o_grant, o_busy, o_timeout
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin sharing of one UART transmitter with done timeout and gap.
// Revision : 1.0
// =============================================================================
module uart_tx_arbiter #(
    parameter int D_BITS         = 8,
    parameter int NREQ           = 2,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 2400
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int LW = $clog2(NREQ);
    localparam logic [TW-1:0] c_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] c_GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_GAP       = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     last_q, last_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [D_BITS-1:0] data_q, data_d;
    logic [NREQ-1:0]   grant_q, grant_d;

    logic [LW-1:0]     win_idx;
    logic              win_found;
    logic [NREQ-1:0]   ready;
    logic              tx_enable;
    logic              timeout;

    // Rotating priority: the requester just after the last winner looks first.
    always_comb begin : p_arb
        int idx;
        idx       = 0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(last_q) + 1 + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!win_found && bus.i_req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = LW'(idx);
            end
        end
    end

    always_comb begin : p_fsm
        state_d   = state_q;
        last_d    = last_q;
        timer_d   = timer_q;
        gap_d     = gap_q;
        data_d    = data_q;
        grant_d   = grant_q;
        ready     = '0;
        tx_enable = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    ready[win_idx] = 1'b1;
                    last_d         = win_idx;
                    data_d         = bus.i_req_data[win_idx*D_BITS +: D_BITS];
                    grant_d        = NREQ'(1) << win_idx;
                    state_d        = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                tx_enable = 1'b1;
                timer_d   = '0;
                state_d   = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                timer_d = timer_q + 1'b1;
                // A done landing on the final timeout cycle still counts as done.
                if (bus.i_tx_done || (timer_q == c_TMO_LAST)) begin
                    timeout = !bus.i_tx_done;
                    if (GAP_CYCLES == 0) begin
                        grant_d = '0;
                        state_d = S_IDLE;
                    end else begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == c_GAP_LAST) begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            last_q  <= LW'(NREQ - 1);
            timer_q <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            timer_q <= timer_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            grant_q <= grant_d;
        end
    end

    assign bus.o_req_ready = ready;
    assign bus.o_tx_data   = data_q;
    assign bus.o_tx_enable = tx_enable;
    assign bus.o_grant     = grant_q;
    assign bus.o_busy      = (state_q != S_IDLE);
    assign bus.o_timeout   = timeout;
endmodule
`default_nettype wire
